// File: rtl/systolic_feed_scheduler_pkg.sv
// rtl/systolic_feed_scheduler_pkg.sv - shared state type, drain length and lane-packing helpers
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feed_state_t;

    localparam int DEFAULT_MATRIX_SIZE = 2;
    localparam int DEFAULT_DATA_SIZE   = 32;
    localparam int DEFAULT_ADDR_W      = 8;

    // Read latency (1) + skew (n-1) + array propagation (2n-1).
    function automatic int drain_cycles(input int n);
        return 3 * n - 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int lane_bus_w(input int n, input int width);
        return n * width;
    endfunction

endpackage

// File: rtl/systolic_feed_scheduler_if.sv
// rtl/systolic_feed_scheduler_if.sv - operand read bus and skewed array-edge feed bus
interface systolic_feed_scheduler_if
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int ADDR_W      = DEFAULT_ADDR_W
);
    localparam int BUS_W = lane_bus_w(MATRIX_SIZE, DATA_SIZE);

    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [BUS_W-1:0]       rd_data_a;
    logic [BUS_W-1:0]       rd_data_b;
    logic [BUS_W-1:0]       feed_a;
    logic [BUS_W-1:0]       feed_b;
    logic [MATRIX_SIZE-1:0] feed_valid;
    logic                   pe_clear;

    modport master (
        output rd_en, rd_addr, feed_a, feed_b, feed_valid, pe_clear,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  rd_en, rd_addr, feed_a, feed_b, feed_valid, pe_clear,
        output rd_data_a, rd_data_b
    );

endinterface

// File: rtl/systolic_feed_scheduler_skew_delay_line.sv
// rtl/systolic_feed_scheduler_skew_delay_line.sv - DEPTH-stage data+valid delay; invalid data stored as zero
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int DEPTH     = 1,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data
);
    logic [DEPTH-1:0]     vld_q;
    logic [DATA_SIZE-1:0] data_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
        end else if (!hold) begin
            vld_q[0]  <= in_valid;
            data_q[0] <= in_valid ? in_data : '0;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_feed_scheduler.sv
// rtl/systolic_feed_scheduler.sv - one systolic pass: row reads, diagonal skew, drain, done pulse
// Define FEED_STALL_EN to add a stall input that freezes FEED/DRAIN progress.
module systolic_feed_scheduler
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
`ifdef FEED_STALL_EN
    input  logic stall,
`endif
    output logic busy,
    output logic done,
    systolic_feed_scheduler_if.master bus
);
    localparam int DRAIN_CYCLES = drain_cycles(MATRIX_SIZE);
    localparam int K_W          = $clog2(MATRIX_SIZE);
    localparam int D_W          = $clog2(DRAIN_CYCLES);
    localparam logic [K_W-1:0] K_LAST = K_W'(MATRIX_SIZE - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYCLES - 1);

    feed_state_t    state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [D_W-1:0] drain_q, drain_d;
    logic           rd_vld_q;
    logic           stall_active;

`ifdef FEED_STALL_EN
    assign stall_active = stall && (state_q == FEED || state_q == DRAIN);
`else
    assign stall_active = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            drain_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            // The read-valid tag freezes with the skew lines so the held memory word is captured on resume.
            if (!stall_active) begin
                rd_vld_q <= bus.rd_en;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        drain_d      = drain_q;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.pe_clear = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FEED;
                    k_d     = '0;
                end
            end
            FEED: begin
                busy = 1'b1;
                if (!stall_active) begin
                    bus.rd_en    = 1'b1;
                    bus.rd_addr  = ADDR_W'(k_q);
                    bus.pe_clear = (k_q == '0);
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                        k_d     = '0;
                        drain_d = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!stall_active) begin
                    if (drain_q == D_LAST) begin
                        state_d = DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                k_d     = '0;
                drain_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic                 lane_a_valid [MATRIX_SIZE];
    logic                 lane_b_valid [MATRIX_SIZE];
    logic [DATA_SIZE-1:0] lane_a_data  [MATRIX_SIZE];
    logic [DATA_SIZE-1:0] lane_b_data  [MATRIX_SIZE];

    // Lane i: one capture stage plus i skew stages.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        skew_delay_line #(.DEPTH(i + 1), .DATA_SIZE(DATA_SIZE)) u_skew_a (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall_active),
            .in_valid  (rd_vld_q),
            .in_data   (bus.rd_data_a[lane_lsb(i, DATA_SIZE) +: DATA_SIZE]),
            .out_valid (lane_a_valid[i]),
            .out_data  (lane_a_data[i])
        );
        skew_delay_line #(.DEPTH(i + 1), .DATA_SIZE(DATA_SIZE)) u_skew_b (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall_active),
            .in_valid  (rd_vld_q),
            .in_data   (bus.rd_data_b[lane_lsb(i, DATA_SIZE) +: DATA_SIZE]),
            .out_valid (lane_b_valid[i]),
            .out_data  (lane_b_data[i])
        );
    end

    always_comb begin
        bus.feed_valid = '0;
        bus.feed_a     = '0;
        bus.feed_b     = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (lane_a_valid[i] && lane_b_valid[i] && !stall_active) begin
                bus.feed_valid[i]                                = 1'b1;
                bus.feed_a[lane_lsb(i, DATA_SIZE) +: DATA_SIZE] = lane_a_data[i];
                bus.feed_b[lane_lsb(i, DATA_SIZE) +: DATA_SIZE] = lane_b_data[i];
            end
        end
    end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// tb/tb_systolic_feed_scheduler.sv - scoreboard bench: N=2 main instance, N=4 skew instance; FEED_STALL_EN adds stall test
module tb_systolic_feed_scheduler;
    localparam int N2 = 2;
    localparam int N4 = 4;
    localparam int DS = 32;
    localparam int AW = 8;
    localparam int NO_STALL = 1 << 30;

    typedef struct {
        int          cyc;
        logic        rd_en;
        logic [AW-1:0] addr;
        logic        clr;
        logic        busy;
        logic        done;
    } ctl_t;

    typedef struct {
        int          cyc;
        int          lane;
        logic [DS-1:0] a;
        logic [DS-1:0] b;
    } feed_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start4, stall;
    logic busy, done, busy4, done4;
    int   cyc, errors, checks;

    ctl_t  ctl_q[$];
    feed_t feed_q[$];
    feed_t feed4_q[$];

    systolic_feed_scheduler_if #(.MATRIX_SIZE(N2), .DATA_SIZE(DS), .ADDR_W(AW)) bus2 ();
    systolic_feed_scheduler_if #(.MATRIX_SIZE(N4), .DATA_SIZE(DS), .ADDR_W(AW)) bus4 ();

    systolic_feed_scheduler #(.MATRIX_SIZE(N2), .DATA_SIZE(DS), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef FEED_STALL_EN
        .stall (stall),
`endif
        .busy  (busy),
        .done  (done),
        .bus   (bus2.master)
    );

    systolic_feed_scheduler #(.MATRIX_SIZE(N4), .DATA_SIZE(DS), .ADDR_W(AW)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
`ifdef FEED_STALL_EN
        .stall (1'b0),
`endif
        .busy  (busy4),
        .done  (done4),
        .bus   (bus4.master)
    );

    function automatic logic [DS-1:0] a2_val(input int k, input int i);
        return DS'(1 + k + 2 * i);
    endfunction

    function automatic logic [DS-1:0] b2_val(input int k, input int i);
        return DS'(256 + 16 * k + i);
    endfunction

    // Operand memories: registered read, output holds when rd_en is low.
    always @(posedge clk) begin
        if (bus2.rd_en) begin
            for (int i = 0; i < N2; i++) begin
                bus2.rd_data_a[i*DS +: DS] <= a2_val(int'(bus2.rd_addr), i);
                bus2.rd_data_b[i*DS +: DS] <= b2_val(int'(bus2.rd_addr), i);
            end
        end
        if (bus4.rd_en) begin
            for (int i = 0; i < N4; i++) begin
                bus4.rd_data_a[i*DS +: DS] <= DS'(100 * i + int'(bus4.rd_addr));
                bus4.rd_data_b[i*DS +: DS] <= DS'(100 * i + int'(bus4.rd_addr) + 50);
            end
        end
    end

    // Expected N=2 pass accepted at cycle s; cycles from sa onward slip by sl stall cycles.
    task automatic push_pass(input int s, input int sa, input int sl);
        int d;
        d = 3 * N2 - 1;
        for (int t = s + 1; t <= s + N2 + d + 1; t++) begin
            ctl_t c;
            if (t == sa) begin
                for (int j = 0; j < sl; j++) begin
                    ctl_q.push_back('{sa + j, 1'b0, AW'(0), 1'b0, 1'b1, 1'b0});
                end
            end
            c.cyc   = (t >= sa) ? t + sl : t;
            c.rd_en = (t <= s + N2);
            c.addr  = c.rd_en ? AW'(t - s - 1) : AW'(0);
            c.clr   = (t == s + 1);
            c.busy  = (t <= s + N2 + d);
            c.done  = (t == s + N2 + d + 1);
            ctl_q.push_back(c);
        end
        for (int t = s + 3; t <= s + 2 * N2 + 1; t++) begin
            for (int i = 0; i < N2; i++) begin
                int k;
                k = t - s - 3 - i;
                if (k >= 0 && k < N2) begin
                    feed_q.push_back('{(t >= sa) ? t + sl : t, i, a2_val(k, i), b2_val(k, i)});
                end
            end
        end
    endtask

    // Advance one cycle, apply inputs just after the edge, score the N=2 instance mid-cycle.
    task automatic step(input logic st, input logic sl);
        logic [AW+3:0]     exp_c, got_c;
        logic [N2-1:0]     ev;
        logic [N2*DS-1:0]  ea, eb;
        @(posedge clk);
        cyc++;
        #1;
        start = st;
        stall = sl;
        @(negedge clk);
        exp_c = '0;
        if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
            ctl_t c;
            c = ctl_q.pop_front();
            exp_c = {c.rd_en, c.addr, c.clr, c.busy, c.done};
        end
        got_c = {bus2.rd_en, bus2.rd_addr, bus2.pe_clear, busy, done};
        checks++;
        if (got_c !== exp_c) begin
            errors++;
            $display("FAIL ctl cyc=%0d {rd_en,addr,clr,busy,done} got=%h want=%h", cyc, got_c, exp_c);
        end
        ev = '0;
        ea = '0;
        eb = '0;
        while (feed_q.size() > 0 && feed_q[0].cyc == cyc) begin
            feed_t f;
            f = feed_q.pop_front();
            ev[f.lane]            = 1'b1;
            ea[f.lane*DS +: DS]   = f.a;
            eb[f.lane*DS +: DS]   = f.b;
        end
        checks++;
        if ({bus2.feed_valid, bus2.feed_a, bus2.feed_b} !== {ev, ea, eb}) begin
            errors++;
            $display("FAIL feed cyc=%0d valid=%b a=%h b=%h want valid=%b a=%h b=%h",
                     cyc, bus2.feed_valid, bus2.feed_a, bus2.feed_b, ev, ea, eb);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (ctl_q.size() != 0 || feed_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover ctl=%0d feed=%0d want 0", name, ctl_q.size(), feed_q.size());
        end
    endtask

    task automatic test_reset();
        int s;
        #1;
        checks++;
        if ({busy, done, bus2.rd_en, bus2.pe_clear, bus2.rd_addr, bus2.feed_valid, bus2.feed_a, bus2.feed_b} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b rd_en=%b valid=%b want all 0", busy, done, bus2.rd_en, bus2.feed_valid);
        end
        step(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0);
        s = cyc;
        push_pass(s, NO_STALL, 0);
        repeat (4) step(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, bus2.feed_valid} !== '0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b valid=%b want 0", busy, done, bus2.feed_valid);
        end
        ctl_q.delete();
        feed_q.delete();
        repeat (2) step(1'b0, 1'b0);
        reset = 1'b0;
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        push_pass(cyc, NO_STALL, 0);
        repeat (9) step(1'b0, 1'b0);
        check_drained("reset_recover");
    endtask

    task automatic test_basic_pass();
        step(1'b1, 1'b0);
        push_pass(cyc, NO_STALL, 0);
        repeat (9) step(1'b0, 1'b0);
        check_drained("basic_pass");
    endtask

    task automatic test_start_ignored();
        int s;
        step(1'b1, 1'b0);
        s = cyc;
        push_pass(s, NO_STALL, 0);
        repeat (9) step(1'b1, 1'b0);
        push_pass(s + 9, NO_STALL, 0);
        repeat (9) step(1'b0, 1'b0);
        check_drained("start_ignored");
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0);
        push_pass(cyc, NO_STALL, 0);
        repeat (8) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        push_pass(cyc, NO_STALL, 0);
        repeat (9) step(1'b0, 1'b0);
        check_drained("back_to_back");
    endtask

    task automatic test_skew();
        int s, first_rd, first_l3;
        logic [AW+3:0]    exp_c, got_c;
        logic [AW-1:0]    e_addr;
        logic [N4-1:0]    ev;
        logic [N4*DS-1:0] ea, eb;
        first_rd = -1;
        first_l3 = -1;
        start4   = 1'b1;
        s        = cyc;
        for (int t = s + 3; t <= s + 2 * N4 + 1; t++) begin
            for (int i = 0; i < N4; i++) begin
                int k;
                k = t - s - 3 - i;
                if (k >= 0 && k < N4) begin
                    feed4_q.push_back('{t, i, DS'(100 * i + k), DS'(100 * i + k + 50)});
                end
            end
        end
        for (int j = 1; j <= 4 * N4 + 1; j++) begin
            step(1'b0, 1'b0);
            start4 = 1'b0;
            e_addr = (j <= N4) ? AW'(j - 1) : AW'(0);
            exp_c  = {(j <= N4), e_addr, (j == 1), (j <= 4 * N4 - 1), (j == 4 * N4)};
            got_c  = {bus4.rd_en, bus4.rd_addr, bus4.pe_clear, busy4, done4};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL skew_ctl cyc=%0d got=%h want=%h", cyc, got_c, exp_c);
            end
            ev = '0;
            ea = '0;
            eb = '0;
            while (feed4_q.size() > 0 && feed4_q[0].cyc == cyc) begin
                feed_t f;
                f = feed4_q.pop_front();
                ev[f.lane]          = 1'b1;
                ea[f.lane*DS +: DS] = f.a;
                eb[f.lane*DS +: DS] = f.b;
            end
            checks++;
            if ({bus4.feed_valid, bus4.feed_a, bus4.feed_b} !== {ev, ea, eb}) begin
                errors++;
                $display("FAIL skew_feed cyc=%0d valid=%b a=%h want valid=%b a=%h",
                         cyc, bus4.feed_valid, bus4.feed_a, ev, ea);
            end
            if (bus4.rd_en && first_rd < 0) first_rd = cyc;
            if (bus4.feed_valid[3] && first_l3 < 0) first_l3 = cyc;
        end
        checks++;
        if (first_rd < 0 || first_l3 - first_rd != 5) begin
            errors++;
            $display("FAIL skew_lane3_latency got=%0d want=5", first_l3 - first_rd);
        end
        checks++;
        if (feed4_q.size() != 0) begin
            errors++;
            $display("FAIL skew_leftover got=%0d want=0", feed4_q.size());
        end
    endtask

`ifdef FEED_STALL_EN
    task automatic test_stall();
        int s;
        step(1'b1, 1'b0);
        s = cyc;
        push_pass(s, s + 2, 3);
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b0);
        check_drained("stall");
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        start  = 1'b0;
        start4 = 1'b0;
        stall  = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_basic_pass();
        test_start_ignored();
        test_back_to_back();
        test_skew();
`ifdef FEED_STALL_EN
        test_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feed_scheduler.md
Name: systolic_feed_scheduler

Overview:
- Sequences one matrix-multiply pass of the N×N systolic array.
- Issues row reads to the A and B operand memories and applies the diagonal skew: lane i is delayed i cycles.
- Drives skewed operand wavefronts and per-lane valids into the array edge, waits for the pipeline to drain, then pulses done.
- Replaces ad-hoc fixed-interval fetching with a start/busy/done handshake.

Parameters:
- MATRIX_SIZE, 2, array dimension N (lanes, and steps per pass); N ≥ 2.
- DATA_SIZE, 32, operand width in bits.
- ADDR_W, 8, operand memory address width; requires 2^ADDR_W ≥ N.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  begin a pass; honoured only in IDLE.
- busy  output  1  high in FEED and DRAIN.
- done  output  1  single-cycle pulse at pass end.
- pe_clear  output  1  one-cycle accumulator clear to the array, high in the first FEED cycle.
- rd_en  output  1  operand read strobe, shared by the A and B memories.
- rd_addr  output  ADDR_W  step index k.
- rd_data_a  input  N*DATA_SIZE  A column k; lane i at bits [i*DATA_SIZE +: DATA_SIZE]; valid the cycle after rd_en.
- rd_data_b  input  N*DATA_SIZE  B row k; same packing.
- feed_a  output  N*DATA_SIZE  skewed row-edge operands.
- feed_b  output  N*DATA_SIZE  skewed column-edge operands.
- feed_valid  output  N  per-lane valid for feed_a/feed_b lane i.

Behaviour:
- Reset behaviour:
  - reset is asynchronous, active-high; clock is clk.
  - On reset, all outputs are 0, state is IDLE, counters are 0, and every skew register is cleared.
  - Reset asserted mid-pass aborts the pass immediately; no done pulse.
- State machine IDLE → FEED → DRAIN → DONE → IDLE:
  - IDLE: start=1 sampled at a clock edge moves to FEED with k=0. start is ignored in every other state; it is not queued.
  - FEED: lasts exactly N cycles. Each cycle rd_en=1 and rd_addr=k, with k = 0..N-1; k increments per cycle. pe_clear=1 only in the cycle with k=0. After k=N-1, move to DRAIN.
  - DRAIN: lasts exactly DRAIN_CYCLES = 3N-1 cycles (localparam): 1 read latency + N-1 skew + 2N-1 array propagation. rd_en=0.
  - DONE: 1 cycle, done=1, busy=0, then IDLE. A start in the DONE cycle is ignored.
- Skew datapath:
  - A valid pipeline tags rd_data one cycle after rd_en.
  - Lane i of A and B passes through one capture register plus i delay registers.
  - Latency from rd_en for step k to feed_a/feed_b lane i for step k: 2+i cycles.
  - feed_valid[i] accompanies the data. When not valid, feed_a/feed_b lane data is forced to 0, never stale.
- No arithmetic on data. The k and drain counters are sized with $clog2 and never wrap within a pass.

Optional Feature:
- Macro FEED_STALL_EN.
- When defined:
  - An extra input port stall (1 bit) is added.
  - While stall=1 in FEED or DRAIN: the state, k, and drain counter hold; rd_en=0; the skew registers hold.
  - feed_valid is forced to 0 during stall; data registers are not cleared.
  - Resuming continues exactly where the pass left off.
  - stall is ignored in IDLE and DONE.
- When undefined: no stall port; the timing above is exact.

Decomposition:
- Package systolic_pkg holds:
  - typedef enum logic [1:0] feed_state_t {IDLE, FEED, DRAIN, DONE};
  - function drain_cycles(n) returning 3n-1;
  - lane-packing helper localparams.
- One sub-module, skew_delay_line:
  - Parameters DEPTH and DATA_SIZE; carries data and valid; async reset clears it; optional hold input.
  - Instantiated 2N times, with DEPTH=i+1 for lane i.

Test Plan:
- Reset: assert reset mid-DRAIN with N=2 → same cycle busy=0 and feed_valid=0; state returns to IDLE; no done pulse; next start runs a full normal pass.
- Basic pass: N=2, start pulse at cycle 0.
  - rd_en high cycles 1–2 with rd_addr 0,1; pe_clear high cycle 1 only.
  - Memory returns A col0={1,3}, col1={2,4}.
  - feed_a lane0 = 1@cycle3, 2@cycle4; lane1 = 3@cycle4, 4@cycle5; zero with valid=0 elsewhere.
  - busy cycles 1–7; done=1 cycle 8 only.
- Start ignored: start held high for the whole pass → exactly one pass; next pass starts at the first IDLE cycle after DONE (cycle 9).
- Skew check: N=4, lane data = 100*i + k → feed_a lane 3 step 0 (value 300) appears 5 cycles after first rd_en; feed_valid pattern forms a diagonal staircase.
- FEED_STALL_EN: N=2, stall high for 3 cycles starting at the second FEED cycle → rd_addr=1 issued after stall drops; every feed output is delayed by exactly 3 cycles; done at cycle 11.
- Back-to-back: start asserted the cycle after done → second pass identical to the first and pe_clear re-pulses.
